// File: rtl/apb_uart_completer.sv
// APB completer fronting a byte-stream UART core: TX queue, RX holding register, CTRL/STATUS/CLEAR, irq.
// Optional internal loopback (CTRL bit3) is compiled in only when UART_APB_LOOPBACK_EN is defined.
module apb_uart_completer #(
    parameter int TXQ_DEPTH  = 4,
    parameter int WAIT_LIMIT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        irq
);
    localparam int AW = $clog2(TXQ_DEPTH);
    localparam int WW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_STALL, S_DONE} state_t;

    state_t          r_state;
    logic            r_write;
    logic [3:0]      r_addr;
    logic [7:0]      r_wdata;
    logic [WW-1:0]   r_wait;
    logic [31:0]     r_prdata;
    logic            r_pready;
    logic            r_pslverr;

    logic [7:0]      r_mem [TXQ_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [4:0]      r_count;

    logic [7:0]      r_rx_hold;
    logic            r_rx_avail;
    logic            r_overrun;
    logic [3:0]      r_ctrl;
    logic            r_irq;

    logic            w_full, w_empty, w_lb, w_tx_valid, w_lb_move, w_pop, w_push;
    logic            w_is_data, w_is_stat, w_is_ctrl, w_is_clr, w_acc;
    logic            w_flush, w_clr_ovr, w_ctrl_wr, w_rx_pop, w_rx_in_v;
    logic [7:0]      w_rx_in_b;
    logic [31:0]     w_status;
    logic [31:0]     w_rdata;
    logic            w_err;
    logic            w_unused;

    assign w_unused = ^{PADDR[31:4], PWDATA[31:8]};

    assign w_full  = (r_count == 5'(TXQ_DEPTH));
    assign w_empty = (r_count == 5'd0);

`ifdef UART_APB_LOOPBACK_EN
    assign w_lb = r_ctrl[3];
`else
    assign w_lb = 1'b0;
`endif

    assign w_tx_valid = !w_empty & r_ctrl[0] & !w_lb;
    assign w_lb_move  = w_lb & !w_empty & !r_rx_avail;
    assign w_pop      = (w_tx_valid & tx_ready) | w_lb_move;

    assign w_is_data = (r_addr == 4'h0);
    assign w_is_stat = (r_addr == 4'h4);
    assign w_is_ctrl = (r_addr == 4'h8);
    assign w_is_clr  = (r_addr == 4'hC);
    assign w_acc     = (r_state == S_ACCESS);

    // Push decision uses the registered full flag, so a same-cycle pop never makes room early.
    assign w_push    = r_write & w_is_data & r_ctrl[0] & !w_full &
                       (w_acc | ((r_state == S_STALL) & PSEL));
    assign w_flush   = w_acc & r_write & w_is_clr & r_wdata[1];
    assign w_clr_ovr = w_acc & r_write & w_is_clr & r_wdata[0];
    assign w_ctrl_wr = w_acc & r_write & w_is_ctrl;
    assign w_rx_pop  = w_acc & !r_write & w_is_data & r_rx_avail;

    assign w_rx_in_v = w_lb ? w_lb_move : rx_valid;
    assign w_rx_in_b = w_lb ? r_mem[r_rptr] : rx_byte;

    assign w_status = {23'b0, r_count, r_overrun, r_rx_avail, w_empty, w_full};

    always_comb begin
        w_err   = 1'b0;
        w_rdata = 32'h0;
        case (r_addr)
            4'h0: begin
                if (r_write)         w_err   = !r_ctrl[0];
                else if (r_rx_avail) w_rdata = {24'b0, r_rx_hold};
                else                 w_err   = 1'b1;
            end
            4'h4:    if (!r_write) w_rdata = w_status;
            4'h8:    if (!r_write) w_rdata = {28'b0, r_ctrl};
            4'hC:    w_rdata = 32'h0;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_addr    <= 4'h0;
            r_wdata   <= 8'h0;
            r_wait    <= '0;
            r_prdata  <= 32'h0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_write <= PWRITE;
                        r_addr  <= PADDR[3:0];
                        r_wdata <= PWDATA[7:0];
                        r_wait  <= '0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_write && w_is_data && r_ctrl[0] && w_full) begin
                        r_state <= S_STALL;
                    end else begin
                        r_state   <= S_DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= w_rdata;
                    end
                end
                S_STALL: begin
                    if (!PSEL) begin
                        r_state <= S_IDLE;
                    end else if (!w_full) begin
                        r_state   <= S_DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b0;
                        r_prdata  <= 32'h0;
                    end else if (r_wait == WW'(WAIT_LIMIT - 1)) begin
                        r_state   <= S_DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                        r_prdata  <= 32'h0;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push) r_mem[r_wptr] <= r_wdata;
    end

    // Flush wins over any pop issued in the same cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rx_hold  <= 8'h0;
            r_rx_avail <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_rx_in_v) begin
                if (!r_rx_avail || w_rx_pop) begin
                    r_rx_hold  <= w_rx_in_b;
                    r_rx_avail <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_rx_pop) begin
                r_rx_avail <= 1'b0;
            end
            if (w_clr_ovr) r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_ctrl <= 4'h1;
            r_irq  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
`ifdef UART_APB_LOOPBACK_EN
                r_ctrl <= r_wdata[3:0];
`else
                r_ctrl <= {1'b0, r_wdata[2:0]};
`endif
            end
            r_irq <= (r_ctrl[1] & r_rx_avail) | (r_ctrl[2] & w_empty) | r_overrun;
        end
    end

    assign PRDATA   = r_prdata;
    assign PREADY   = r_pready;
    assign PSLVERR  = r_pslverr;
    assign tx_valid = w_tx_valid;
    assign tx_byte  = w_empty ? 8'h00 : r_mem[r_rptr];
    assign irq      = r_irq;

endmodule
